dct_transpose_buf: RTL and testbench

Ping-pong 4x4 transpose buffer for the 2D DCT datapath. It sits directly downstream of the row-product RAM, which emits one 4-word row pack of 38-bit coefficients per cycle, four packs per block. It stores each 4x4 block and re-emits it column by column, so the second (column) 1-D DCT pass receives transposed data. Two banks let one block be written while the previous one is read, sustaining one pack per cycle.

---
 rtl/dct_pkg.sv | 13 +
 rtl/tp_bank.sv | 36 +++
 rtl/dct_transpose_buf.sv | 93 +++++++++
 tb/tb_dct_transpose_buf.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the 2D DCT transpose path and the helper that locates
// element k inside a packed row or column (element 0 occupies the MSBs).
package dct_pkg;

    localparam int DATA_W = 38;
    localparam int N      = 4;
    localparam int ROW_W  = N * DATA_W;

    function automatic int elem_lsb(input int k, input int n, input int w);
        return (n - 1 - k) * w;
    endfunction

endpackage

// File: rtl/tp_bank.sv
// One N x N coefficient bank: written a whole row at a time, read a whole
// column at a time through a combinational mux.
module tp_bank
    import dct_pkg::elem_lsb;
#(
    parameter int DATA_W = dct_pkg::DATA_W,
    parameter int N      = dct_pkg::N,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    wr_row,
    input  logic [N*DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]    rd_col,
    output logic [N*DATA_W-1:0] rd_data
);

    // Contents are never observable before being written, so no reset.
    logic [DATA_W-1:0] mem [N][N];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <= wr_data[elem_lsb(c, N, DATA_W) +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < N; r++) begin
            rd_data[elem_lsb(r, N, DATA_W) +: DATA_W] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 4x4 transpose buffer: one bank fills with row packs while the other
// drains as column packs through a valid/ready output register.
module dct_transpose_buf #(
    parameter int DATA_W = dct_pkg::DATA_W,
    parameter int N      = dct_pkg::N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [N*DATA_W-1:0] in_row,
    output logic                in_ready,
    output logic                out_valid,
    output logic [N*DATA_W-1:0] out_col,
    output logic                out_last,
    input  logic                out_ready,
    output logic                ovf
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [1:0]          full;
    logic [1:0]          full_nxt;
    logic                wr_sel;
    logic                rd_sel;
    logic [IDX_W-1:0]    wr_row;
    logic [IDX_W-1:0]    rd_col;
    logic [N*DATA_W-1:0] bank_col [2];
    logic                wr_fire;
    logic                wr_done;
    logic                rd_load;
    logic                rd_done;

    assign in_ready = !full[wr_sel];
    assign wr_fire  = in_valid && in_ready;
    assign wr_done  = wr_fire && (wr_row == LAST);
    assign rd_load  = (!out_valid || out_ready) && full[rd_sel];
    assign rd_done  = rd_load && (rd_col == LAST);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tp_bank #(
            .DATA_W (DATA_W),
            .N      (N),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk     (clk),
            .we      (wr_fire && (wr_sel == 1'(b))),
            .wr_row  (wr_row),
            .wr_data (in_row),
            .rd_col  (rd_col),
            .rd_data (bank_col[b])
        );
    end

    // Writer and reader always point at different banks when both act, so a
    // set and a clear on the same edge never collide.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_sel] = 1'b1;
        if (rd_done) full_nxt[rd_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_row    <= '0;
            rd_col    <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_row <= wr_done ? '0 : wr_row + 1'b1;
                if (wr_done) wr_sel <= !wr_sel;
            end
            if (in_valid && !in_ready) ovf <= 1'b1;
            if (rd_load) begin
                out_col   <= bank_col[rd_sel];
                out_last  <= (rd_col == LAST);
                out_valid <= 1'b1;
                rd_col    <= rd_done ? '0 : rd_col + 1'b1;
                if (rd_done) rd_sel <= !rd_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Randomized bench for dct_transpose_buf against a queue-based transpose model.
module tb_dct_transpose_buf;

    localparam int DATA_W = dct_pkg::DATA_W;
    localparam int N      = dct_pkg::N;
    localparam int ROW_W  = dct_pkg::ROW_W;

    typedef logic [ROW_W-1:0] row_t;
    typedef struct {
        row_t col;
        logic last;
    } exp_t;

    logic clk;
    logic rst;
    logic in_valid;
    row_t in_row;
    logic in_ready;
    logic out_valid;
    row_t out_col;
    logic out_last;
    logic out_ready;
    logic ovf;

    int checks = 0;
    int passes = 0;

    logic [DATA_W-1:0] blk [N][N];
    int   rows_held = 0;
    exp_t exp_q[$];

    logic obs_ready, obs_valid, obs_last, acc, cons;
    row_t obs_col;

    dct_transpose_buf #(.DATA_W(DATA_W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: collect accepted rows; a complete block becomes N transposed columns.
    task automatic model_accept(input row_t row);
        row_t c_v;
        for (int k = 0; k < N; k++) blk[rows_held][k] = row[(N-1-k)*DATA_W +: DATA_W];
        rows_held++;
        if (rows_held == N) begin
            for (int c = 0; c < N; c++) begin
                c_v = '0;
                for (int r = 0; r < N; r++) c_v[(N-1-r)*DATA_W +: DATA_W] = blk[r][c];
                exp_q.push_back('{col: c_v, last: (c == N-1)});
            end
            rows_held = 0;
        end
    endtask

    function automatic row_t rand_row();
        row_t r;
        logic [63:0] t;
        for (int k = 0; k < N; k++) begin
            t = {$urandom(), $urandom()};
            r[(N-1-k)*DATA_W +: DATA_W] = t[DATA_W-1:0];
        end
        return r;
    endfunction

    function automatic row_t elem_row(input int r, input int base);
        row_t v;
        for (int k = 0; k < N; k++) v[(N-1-k)*DATA_W +: DATA_W] = DATA_W'(base*r + k);
        return v;
    endfunction

    // Called at a negedge: drive, observe the cycle's state, then advance one cycle.
    task automatic drive_cycle(input logic v, input row_t row, input logic rdy);
        in_valid  = v;
        in_row    = row;
        out_ready = rdy;
        #1;
        obs_ready = in_ready;
        obs_valid = out_valid;
        obs_col   = out_col;
        obs_last  = out_last;
        acc  = v && in_ready;
        cons = out_valid && rdy;
        if (acc) model_accept(row);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_cycle(1'b0, '0, 1'b0);
        rst = 1'b0;
        rows_held = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_col !== '0) $display("[TB] FAIL reset_out_col got %h want 0", out_col); else passes++;
        checks++; if (out_last !== 1'b0) $display("[TB] FAIL reset_out_last got %b want 0", out_last); else passes++;
        checks++; if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", ovf); else passes++;
    endtask

    task automatic test_single_block();
        row_t want;
        int c;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(i < N, (i < N) ? elem_row(i, 16) : '0, 1'b1);
            checks++;
            if (obs_valid !== (i >= 5 && i <= 8))
                $display("[TB] FAIL single_valid cyc %0d got %b want %b", i, obs_valid, (i >= 5 && i <= 8));
            else passes++;
            if (i >= 5 && i <= 8) begin
                c = i - 5;
                for (int r = 0; r < N; r++) want[(N-1-r)*DATA_W +: DATA_W] = DATA_W'(16*r + c);
                checks++;
                if (obs_col !== want) $display("[TB] FAIL single_col %0d got %h want %h", c, obs_col, want);
                else passes++;
                checks++;
                if (obs_last !== (c == 3)) $display("[TB] FAIL single_last %0d got %b want %b", c, obs_last, (c == 3));
                else passes++;
            end
        end
    endtask

    task automatic test_streaming();
        exp_t e;
        int n_cons = 0, first = -1, lastc = -1, drops = 0;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            drive_cycle(i < 32, rand_row(), 1'b1);
            if (i < 32 && !obs_ready) drops++;
            if (cons) begin
                if (first < 0) first = i;
                lastc = i;
                n_cons++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL stream_extra cyc %0d got col %h want none", i, obs_col);
                else begin
                    e = exp_q.pop_front();
                    if (obs_col !== e.col || obs_last !== e.last)
                        $display("[TB] FAIL stream_col cyc %0d got %h/%b want %h/%b", i, obs_col, obs_last, e.col, e.last);
                    else passes++;
                end
            end
        end
        checks++; if (drops != 0) $display("[TB] FAIL stream_in_ready_drops got %0d want 0", drops); else passes++;
        checks++; if (n_cons != 32) $display("[TB] FAIL stream_count got %0d want 32", n_cons); else passes++;
        checks++;
        if (first != 5 || lastc != 36) $display("[TB] FAIL stream_window got %0d..%0d want 5..36", first, lastc);
        else passes++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        row_t held;
        int n_cons = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b1, rand_row(), 1'b0);
            checks++;
            if (obs_ready !== (i < 8)) $display("[TB] FAIL bp_in_ready row %0d got %b want %b", i, obs_ready, (i < 8));
            else passes++;
        end
        checks++; if (ovf !== 1'b1) $display("[TB] FAIL bp_ovf got %b want 1", ovf); else passes++;
        held = exp_q[0].col;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, 1'b0);
            checks++;
            if (obs_valid !== 1'b1 || obs_col !== held)
                $display("[TB] FAIL bp_hold cyc %0d got %b/%h want 1/%h", i, obs_valid, obs_col, held);
            else passes++;
        end
        for (int j = 0; j < 12; j++) begin
            drive_cycle(1'b0, '0, 1'b1);
            if (j < 5) begin
                checks++;
                if (obs_ready !== (j >= 3)) $display("[TB] FAIL bp_release cyc %0d got %b want %b", j, obs_ready, (j >= 3));
                else passes++;
            end
            if (cons) begin
                n_cons++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL bp_extra cyc %0d got col %h want none", j, obs_col);
                else begin
                    e = exp_q.pop_front();
                    if (obs_col !== e.col || obs_last !== e.last)
                        $display("[TB] FAIL bp_col cyc %0d got %h/%b want %h/%b", j, obs_col, obs_last, e.col, e.last);
                    else passes++;
                end
            end
        end
        checks++; if (n_cons != 8) $display("[TB] FAIL bp_count got %0d want 8", n_cons); else passes++;
    endtask

    task automatic test_random();
        exp_t e;
        int sent = 0, n_cons = 0, cyc = 0;
        logic v;
        do_reset();
        while ((n_cons < 400 || cyc < 5) && cyc < 6000) begin
            v = (sent < 400) && in_ready;
            drive_cycle(v, rand_row(), 1'($urandom_range(0, 1)));
            if (acc) sent++;
            if (cons) begin
                n_cons++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL rand_extra cyc %0d got col %h want none", cyc, obs_col);
                else begin
                    e = exp_q.pop_front();
                    if (obs_col !== e.col || obs_last !== e.last)
                        $display("[TB] FAIL rand_col cyc %0d got %h/%b want %h/%b", cyc, obs_col, obs_last, e.col, e.last);
                    else passes++;
                end
            end
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, '0, 1'b1);
            checks++;
            if (obs_valid !== 1'b0) $display("[TB] FAIL rand_tail cyc %0d got valid %b want 0", i, obs_valid);
            else passes++;
        end
        checks++; if (n_cons != 400) $display("[TB] FAIL rand_count got %0d want 400", n_cons); else passes++;
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL rand_pending got %0d want 0", exp_q.size()); else passes++;
        checks++; if (ovf !== 1'b0) $display("[TB] FAIL rand_ovf got %b want 0", ovf); else passes++;
    endtask

    task automatic test_reset_mid_block();
        exp_t e;
        int n_cons = 0;
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, rand_row(), 1'b0);
        drive_cycle(1'b0, '0, 1'b0);
        checks++; if (obs_valid !== 1'b1) $display("[TB] FAIL mid_pending got %b want 1", obs_valid); else passes++;
        do_reset();
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_in_ready got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_col !== '0) $display("[TB] FAIL mid_out_col got %h want 0", out_col); else passes++;
        checks++; if (out_last !== 1'b0) $display("[TB] FAIL mid_out_last got %b want 0", out_last); else passes++;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(i < N, rand_row(), 1'b1);
            if (cons) begin
                n_cons++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL mid_extra cyc %0d got col %h want none", i, obs_col);
                else begin
                    e = exp_q.pop_front();
                    if (obs_col !== e.col || obs_last !== e.last)
                        $display("[TB] FAIL mid_col cyc %0d got %h/%b want %h/%b", i, obs_col, obs_last, e.col, e.last);
                    else passes++;
                end
            end
        end
        checks++; if (n_cons != N) $display("[TB] FAIL mid_count got %0d want %0d", n_cons, N); else passes++;
    endtask

    task automatic test_max_values();
        exp_t e;
        row_t r;
        int n_cons = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            r = '0;
            if (i < 2*N)
                for (int k = 0; k < N; k++)
                    r[(N-1-k)*DATA_W +: DATA_W] = (((i % N) + k + (i / N)) % 2 == 1) ? {DATA_W{1'b1}} : '0;
            drive_cycle(i < 2*N, r, 1'b1);
            if (cons) begin
                n_cons++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL max_extra cyc %0d got col %h want none", i, obs_col);
                else begin
                    e = exp_q.pop_front();
                    if (obs_col !== e.col || obs_last !== e.last)
                        $display("[TB] FAIL max_col cyc %0d got %h/%b want %h/%b", i, obs_col, obs_last, e.col, e.last);
                    else passes++;
                end
            end
        end
        checks++; if (n_cons != 2*N) $display("[TB] FAIL max_count got %0d want %0d", n_cons, 2*N); else passes++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_block();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_mid_block();
        test_max_values();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
